// File: rtl/ddc_oct_sweep_ctrl_if.sv
// Streaming links between the sweep controller and the octal-lane DDC:
// the phase/resync output, the DDC sample input and the sweep result output.
interface ddc_oct_sweep_ctrl_if;
  logic [63:0]  m_axis_phase_tdata;
  logic         m_axis_phase_tvalid;
  logic         resync;
  logic [63:0]  s_axis_ddc_tdata;
  logic         s_axis_ddc_tvalid;
  logic [127:0] m_axis_sweep_tdata;
  logic         m_axis_sweep_tvalid;
  logic         m_axis_sweep_tready;

  // Controller side.
  modport master (
    output m_axis_phase_tdata, m_axis_phase_tvalid, resync,
    input  s_axis_ddc_tdata, s_axis_ddc_tvalid,
    output m_axis_sweep_tdata, m_axis_sweep_tvalid,
    input  m_axis_sweep_tready
  );

  // DDC / result-consumer side.
  modport slave (
    input  m_axis_phase_tdata, m_axis_phase_tvalid, resync,
    output s_axis_ddc_tdata, s_axis_ddc_tvalid,
    input  m_axis_sweep_tdata, m_axis_sweep_tvalid,
    output m_axis_sweep_tready
  );
endinterface

// File: rtl/ddc_oct_sweep_ctrl.sv
// Tone-sweep sequencer: retunes the DDC from a tone table, waits out the
// settle time, integrates I/Q for each tone and emits the tagged sums.
module ddc_oct_sweep_ctrl #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned ACC_W  = 48,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                 s_axis_aclk,
  input  logic                 s_axis_aresetn,
  input  logic                 tbl_wr_en,
  input  logic [ADDR_W-1:0]    tbl_wr_addr,
  input  logic [63:0]          tbl_wr_data,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 loop_en,
  input  logic [ADDR_W:0]      num_tones,
  input  logic [CNT_W-1:0]     settle_len,
  input  logic [CNT_W-1:0]     accum_len,
  ddc_oct_sweep_ctrl_if.master bus,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned PAD_W = 32 - ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_LOAD, S_SETTLE, S_ACCUM, S_OUT
  } state_t;

  logic [63:0]             mem_q [DEPTH];

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       idx_q, idx_d;
  logic [ADDR_W:0]         ntones_q, ntones_d;
  logic                    loop_q, loop_d;
  logic [CNT_W-1:0]        settle_q, settle_d;
  logic [CNT_W-1:0]        alen_q, alen_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_i_q, acc_i_d;
  logic signed [ACC_W-1:0] acc_q_q, acc_q_d;
  logic [63:0]             phase_q, phase_d;
  logic                    phase_vld_q, phase_vld_d;
  logic                    resync_q, resync_d;
  logic                    res_vld_q, res_vld_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic [CNT_W-1:0]        cnt_inc;
  logic [ADDR_W:0]         idx_inc;
  logic signed [ACC_W-1:0] smp_i, smp_q;
  logic                    unused_ddc_bits;

  assign cnt_inc = cnt_q + CNT_W'(1);
  assign idx_inc = {1'b0, idx_q} + (ADDR_W + 1)'(1);
  assign smp_i   = ACC_W'($signed(bus.s_axis_ddc_tdata[29:0]));
  assign smp_q   = ACC_W'($signed(bus.s_axis_ddc_tdata[61:32]));
  assign unused_ddc_bits = ^{bus.s_axis_ddc_tdata[63:62], bus.s_axis_ddc_tdata[31:30]};

  // Tone table: write port always open, no reset on contents.
  always_ff @(posedge s_axis_aclk) begin
    if (tbl_wr_en) mem_q[tbl_wr_addr] <= tbl_wr_data;
  end

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ntones_d    = ntones_q;
    loop_d      = loop_q;
    settle_d    = settle_q;
    alen_d      = alen_q;
    cnt_d       = cnt_q;
    acc_i_d     = acc_i_q;
    acc_q_d     = acc_q_q;
    phase_d     = phase_q;
    phase_vld_d = 1'b0;
    resync_d    = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          ntones_d = num_tones;
          loop_d   = loop_en;
          settle_d = settle_len;
          alen_d   = (accum_len == '0) ? CNT_W'(1) : accum_len;
          idx_d    = '0;
          if (num_tones == '0) done_d  = 1'b1;
          else                 state_d = S_READ;
        end
      end
      S_READ: begin
        // Synchronous table read lands directly in the phase output register.
        phase_d     = mem_q[idx_q];
        phase_vld_d = 1'b1;
        resync_d    = 1'b1;
        state_d     = S_LOAD;
      end
      S_LOAD: begin
        cnt_d   = '0;
        acc_i_d = '0;
        acc_q_d = '0;
        state_d = (settle_q == '0) ? S_ACCUM : S_SETTLE;
      end
      S_SETTLE: begin
        if (bus.s_axis_ddc_tvalid) begin
          if (cnt_inc == settle_q) begin
            cnt_d   = '0;
            state_d = S_ACCUM;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      S_ACCUM: begin
        if (bus.s_axis_ddc_tvalid) begin
          acc_i_d = acc_i_q + smp_i;
          acc_q_d = acc_q_q + smp_q;
          cnt_d   = cnt_inc;
          if (cnt_inc == alen_q) state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (bus.m_axis_sweep_tready) begin
          if (idx_inc < ntones_q) begin
            idx_d   = idx_inc[ADDR_W-1:0];
            state_d = S_READ;
          end else if (loop_q) begin
            idx_d   = '0;
            state_d = S_READ;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides any advance or handshake in the same cycle.
    if (stop && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      done_d      = 1'b1;
      phase_d     = phase_q;
      phase_vld_d = 1'b0;
      resync_d    = 1'b0;
    end

    res_vld_d = (state_d == S_OUT);
    busy_d    = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge s_axis_aclk) begin
    if (!s_axis_aresetn) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      ntones_q    <= '0;
      loop_q      <= 1'b0;
      settle_q    <= '0;
      alen_q      <= '0;
      cnt_q       <= '0;
      acc_i_q     <= '0;
      acc_q_q     <= '0;
      phase_q     <= '0;
      phase_vld_q <= 1'b0;
      resync_q    <= 1'b0;
      res_vld_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ntones_q    <= ntones_d;
      loop_q      <= loop_d;
      settle_q    <= settle_d;
      alen_q      <= alen_d;
      cnt_q       <= cnt_d;
      acc_i_q     <= acc_i_d;
      acc_q_q     <= acc_q_d;
      phase_q     <= phase_d;
      phase_vld_q <= phase_vld_d;
      resync_q    <= resync_d;
      res_vld_q   <= res_vld_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.m_axis_phase_tdata  = phase_q;
  assign bus.m_axis_phase_tvalid = phase_vld_q;
  assign bus.resync              = resync_q;
  assign bus.m_axis_sweep_tvalid = res_vld_q;
  assign bus.m_axis_sweep_tdata  = {{PAD_W{1'b0}}, idx_q, 48'(acc_q_q), 48'(acc_i_q)};
  assign busy                    = busy_q;
  assign done                    = done_q;

endmodule

// File: doc/ddc_oct_sweep_ctrl.md
Name: ddc_oct_sweep_ctrl

Overview:
Sequencer that drives the phase port of the octal-lane DDC through a table of tones. For each tone it:
- issues pinc/poff plus a resync pulse;
- discards DDC output for a programmable settle time;
- integrates a programmable number of DDC output samples;
- emits the integrated I/Q sum tagged with the tone index.

It sits between the register/control logic and the oct DDC phase and output interfaces, replacing a direct software write of a single phase.

Parameters:
ADDR_W, 8, tone-table address width (depth 2^ADDR_W).
ACC_W, 48, accumulator width per I/Q component.
CNT_W, 16, width of settle and integration counters.

Ports:
s_axis_aclk  in  1  clock
s_axis_aresetn  in  1  synchronous active-low reset
tbl_wr_en  in  1  tone-table write strobe
tbl_wr_addr  in  ADDR_W  table write address
tbl_wr_data  in  64  [63:32] poff, [31:0] pinc
start  in  1  sweep start pulse
stop  in  1  abort request
loop_en  in  1  continuous sweep (wrap index to 0)
num_tones  in  ADDR_W+1  tones per sweep
settle_len  in  CNT_W  DDC samples discarded after each retune
accum_len  in  CNT_W  DDC samples integrated per tone
m_axis_phase_tdata  out  64  [63:32] poff, [31:0] pinc, to DDC
m_axis_phase_tvalid  out  1  phase load strobe
resync  out  1  DDS resync strobe
s_axis_ddc_tdata  in  64  [61:32] Q, [29:0] I, signed 30-bit
s_axis_ddc_tvalid  in  1  DDC sample valid
m_axis_sweep_tdata  out  128  [47:0] I sum, [95:48] Q sum, [95+ADDR_W:96] tone index, rest 0
m_axis_sweep_tvalid  out  1  result valid
m_axis_sweep_tready  in  1  result ready
busy  out  1  sweep in progress
done  out  1  one-cycle pulse at sweep end or abort

Behaviour:
- Reset (aresetn=0 at a clock edge):
  - all outputs 0;
  - FSM to IDLE;
  - counters, index and accumulators cleared;
  - table contents undefined/unchanged.
- Table: 2^ADDR_W x 64 synchronous RAM.
  - Writes are accepted in any state.
  - An entry is sampled only in READ. A write to the current index after READ does not affect the current tone.
- start, loop_en, num_tones, settle_len and accum_len are latched in IDLE on start=1. start is ignored when not in IDLE.
- Latched value substitutions: num_tones=0 means the sweep ends immediately (done 1 cycle after start, no output); accum_len=0 is treated as 1.
- FSM:
  - IDLE: on start, index<=0 and go to READ.
  - READ: issue RAM read at index; next state LOAD.
  - LOAD: drive phase_tdata=entry with phase_tvalid=1 and resync=1 for exactly one cycle. Phase_tvalid therefore rises exactly 2 cycles after start is sampled. Clear counters and accumulators. Go to SETTLE, or to ACCUM if settle_len=0.
  - SETTLE: count s_axis_ddc_tvalid beats; at settle_len beats go to ACCUM. The beats are discarded.
  - ACCUM: on each tvalid, sign-extend I[29:0] and Q[61:32] to ACC_W and add. After accum_len beats, go to OUT.
  - OUT: phase_tdata holds its last value. Present the result with tvalid=1; data is stable until tready. On handshake:
    - if index+1 < num_tones: index++ and go to READ;
    - else if loop_en: index<=0 and go to READ;
    - else pulse done and go to IDLE.
- Outside LOAD, m_axis_phase_tvalid=0 and resync=0.
- busy=1 in every state except IDLE.
- DDC samples arriving in IDLE, READ, LOAD or OUT are dropped; there is no backpressure to the DDC.
- Arithmetic: two's complement. 30 bits plus log2(2^CNT_W) gives 46 bits or fewer, so sums cannot overflow at the defaults.
- stop=1 in any non-IDLE state:
  - abort next cycle to IDLE and pulse done;
  - m_axis_sweep_tvalid drops immediately, and any pending result is discarded;
  - stop has priority over a simultaneous handshake or state advance.
- stop in IDLE has no effect. start and stop together in IDLE: start wins.
- Reset mid-sweep behaves identically to power-on reset. No done pulse is issued.

Test Plan:
1. Write 3 entries (pinc=0x100·k, poff=0x10·k), num_tones=3, settle_len=2, accum_len=4, DDC I=5, Q=-3 every cycle, tready=1 -> 3 phase_tvalid+resync pulses, first 2 cycles after start. Outputs: I sum=20, Q sum=-12 (48-bit sign-extended), index 0,1,2. done after third output; busy falls the same cycle.
2. Same setup with tready held 0 for 10 cycles on tone 1 -> tdata stable and tvalid held; no phase_tvalid issued until the handshake. DDC beats arriving during the hold do not change the next tone's sum.
3. DDC tvalid toggling every other cycle, settle_len=0, accum_len=3, I=max (0x1FFFFFFF) -> ACCUM entered directly after LOAD. I sum=0x5FFFFFFD; exactly 3 valid beats counted.
4. loop_en=1, num_tones=2 -> index sequence 0,1,0,1,... with no done. stop asserted in ACCUM -> done pulse, IDLE next cycle, sweep tvalid 0.
5. num_tones=0 -> done 1 cycle after start, no phase_tvalid. accum_len=0 -> single-sample sum.
6. Reset asserted during OUT, and start issued while busy -> outputs 0 after reset; start while busy is ignored (index unchanged).
